rv64g_l1_line_xfer: RTL and testbench
=====================================

# rv64g_l1_line_xfer

Line-transfer engine between the L1 cache controller and the 64-bit beat memory port. It accepts one whole-line refill (read) or writeback (write) command. It breaks the command into consecutive 8-byte beat requests on the req/gnt/rvalid memory interface. Read beats are collected into a line buffer and completion is signalled with a one-cycle pulse. It sits directly upstream of the memory model and downstream of the cache miss/evict logic.

## Interface
- LINE_BYTES, 64, line size in bytes; multiple of 8, at least 16; BEATS = LINE_BYTES/8
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  line command present
- cmd_ready_o  out  1  engine idle, command accepted when valid&ready
- cmd_we_i  in  1  1 = writeback line, 0 = refill line
- cmd_addr_i  in  64  line address; bits [log2(LINE_BYTES)-1:0] ignored (treated as 0)
- cmd_wdata_i  in  LINE_BYTES*8  writeback data, beat k = bits [64k+63:64k]; sampled only at accept
- done_o  out  1  one-cycle pulse: command complete
- line_rdata_o  out  LINE_BYTES*8  refill line buffer
- mem_req_o  out  1  beat request
- mem_we_o  out  1  beat is a write
- mem_be_o  out  8  byte enables, always 8'hFF while mem_req_o
- mem_addr_o  out  64  beat address = line base + 8k
- mem_wdata_o  out  64  write beat data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read beat returning
- mem_rdata_i  in  64  read beat data

## Operation
- States: IDLE, WR, RD, DONE.
- IDLE: cmd_ready_o=1. On accept, latch aligned base address, direction, and write line (WR only). Clear issue counter iss and response counter rsp. Go to WR or RD.
- WR: mem_req_o=1, mem_we_o=1, mem_addr_o = base+8*iss, mem_wdata_o = beat iss.
  - On gnt, iss increments.
  - When gnt occurs with iss=BEATS-1, go to DONE.
- RD: mem_req_o=1 while iss<BEATS, mem_we_o=0.
  - iss increments on gnt; requests stay pipelined and do not wait for rvalid.
  - Each mem_rvalid_i writes mem_rdata_i into beat rsp of the line buffer, then rsp increments.
  - Responses are in order.
  - When rvalid occurs with rsp=BEATS-1, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- When mem_req_o=0, mem_we_o/mem_addr_o/mem_wdata_o are 0.
- Address arithmetic is 64-bit modulo 2^64; no line crossing is possible since the base is aligned.
- mem_rvalid_i is ignored outside RD.
- A rvalid arriving in the same cycle as a gnt updates both counters independently.
- line_rdata_o holds the last completed refill until the next refill overwrites beats. It is undefined-but-stable during a refill, valid from the done_o cycle. Writebacks never alter it.
- Reset, including mid-transfer, forces IDLE immediately. Counters clear and any in-flight beat is abandoned; no done_o.

## Timing
- Reset values: cmd_ready_o=1, done_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, line_rdata_o=0.
- All mem_* and done_o outputs are registered/state-decoded; no combinational path from mem_gnt_i or mem_rvalid_i to any output.
- Timing below assumes accept at edge 0 and a gnt that tracks req.
  - Write, BEATS=8: mem_req_o high cycles 1–8, done_o cycle 9, cmd_ready_o cycle 10.
  - Read, BEATS=8, rvalid two cycles after gnt: mem_req_o cycles 1–8, rvalid cycles 3–10, done_o cycle 11.
- gnt low holds the current beat's address and data unchanged until granted.
- Minimum command-to-command spacing is done cycle + 1.

## Structure
- Shared package rv64g_l1_pkg holds:
  - LINE_BYTES default, BEAT_BYTES=8
  - BEATS and the counter width, $clog2(BEATS)+1
  - the xfer state enum (IDLE/WR/RD/DONE)
- Single module; no sub-module warranted. The line buffer and counters are inline.

## Test plan
- Refill at 0x1000 against the memory model preloaded with mem[0x200+k]=0xA5A5_0000_0000_0000+k -> 8 beats, addresses 0x1000..0x1038, done_o at cycle 11, line_rdata_o beat k = preload k.
- Writeback at 0x2040 with beat k = 0x1111_1111_1111_1111*k, then refill of 0x2040 -> readback line identical, addresses aligned to 0x2040 even when cmd_addr_i=0x207F.
- Gnt throttled to every third cycle during a write -> each beat held stable until granted, done_o exactly once, no beat duplicated or skipped.
- rvalid delayed 5 cycles, and rvalid coincident with a later gnt -> all 8 beats captured in order.
- rst_ni pulsed low after 3 read beats -> outputs at reset values at once, no done_o; the next refill completes correctly.
- Stray mem_rvalid_i pulses in IDLE and during WR -> line_rdata_o unchanged, no done_o.

Source files
------------

// File: rtl/rv64g_l1_pkg.sv
// ---------------------------------------------------------------------------
// rv64g_l1_pkg
// Shared definitions for the L1 line-transfer engine.
//   LINE_BYTES_DEF : default cache line size in bytes
//   BEAT_BYTES     : bytes moved per memory beat (64-bit port)
//   BEATS          : beats per default line
//   CNT_W          : beat counter width, one extra bit so "all beats issued"
//                    (count == BEATS) is representable
//   xfer_state_e   : transfer engine states
//   beat_offset()  : byte offset of a beat index within a line
// ---------------------------------------------------------------------------
package rv64g_l1_pkg;

  localparam int LINE_BYTES_DEF = 64;
  localparam int BEAT_BYTES     = 8;
  localparam int BEATS          = LINE_BYTES_DEF / BEAT_BYTES;
  localparam int CNT_W          = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'd0,
    XFER_WR   = 2'd1,
    XFER_RD   = 2'd2,
    XFER_DONE = 2'd3
  } xfer_state_e;

  // Beats are 8 bytes, so the byte offset is the index shifted by 3.
  function automatic logic [63:0] beat_offset(input logic [63:0] idx);
    return idx << 3;
  endfunction

endpackage

// File: rtl/rv64g_l1_line_xfer.sv
// ---------------------------------------------------------------------------
// rv64g_l1_line_xfer
// Moves one whole cache line between the L1 controller and the 64-bit beat
// memory port. A refill issues pipelined read beats and gathers the returning
// data into a line buffer; a writeback streams the latched line out beat by
// beat. Completion is a single-cycle done_o pulse.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    : line command handshake (ready only when idle)
//   cmd_we_i               : 1 = writeback, 0 = refill
//   cmd_addr_i             : line address, offset bits ignored
//   cmd_wdata_i            : writeback line, beat k in bits [64k+63:64k]
//   done_o                 : one-cycle completion pulse
//   line_rdata_o           : most recent refill line
//   mem_req_o/we_o/be_o    : beat request, direction, byte enables
//   mem_addr_o/wdata_o     : beat address and write data
//   mem_gnt_i              : beat request accepted
//   mem_rvalid_i/rdata_i   : in-order read beat return
// ---------------------------------------------------------------------------
module rv64g_l1_line_xfer
  import rv64g_l1_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [63:0]             cmd_addr_i,
  input  logic [LINE_BYTES*8-1:0] cmd_wdata_i,
  output logic                    done_o,
  output logic [LINE_BYTES*8-1:0] line_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [7:0]              mem_be_o,
  output logic [63:0]             mem_addr_o,
  output logic [63:0]             mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [63:0]             mem_rdata_i
);

  localparam int N_BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int CW      = $clog2(N_BEATS) + 1;
  localparam int OFF     = $clog2(LINE_BYTES);
  localparam int LW      = LINE_BYTES * 8;

  localparam logic [CW-1:0] BEATS_C = CW'(N_BEATS);
  localparam logic [CW-1:0] LAST_C  = CW'(N_BEATS - 1);

  xfer_state_e    state_q;
  logic [CW-1:0]  iss_q;
  logic [CW-1:0]  rsp_q;
  logic [63:0]    base_q;
  logic [LW-1:0]  wline_q;
  logic [LW-1:0]  line_q;

  logic           req_d;
  logic [63:0]    wbeat_d;

  // The line offset bits of the command address are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr_i[OFF-1:0];

  // Transfer FSM: command latch, issue/response counters and the refill
  // line buffer all advance together. Grant and rvalid are handled
  // independently so a read can issue and retire a beat in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= XFER_IDLE;
      iss_q   <= '0;
      rsp_q   <= '0;
      base_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
    end else begin
      case (state_q)
        XFER_IDLE: begin
          if (cmd_valid_i) begin
            base_q <= {cmd_addr_i[63:OFF], {OFF{1'b0}}};
            iss_q  <= '0;
            rsp_q  <= '0;
            if (cmd_we_i) begin
              wline_q <= cmd_wdata_i;
              state_q <= XFER_WR;
            end else begin
              state_q <= XFER_RD;
            end
          end
        end

        XFER_WR: begin
          if (mem_gnt_i) begin
            iss_q <= iss_q + CW'(1);
            if (iss_q == LAST_C) begin
              state_q <= XFER_DONE;
            end
          end
        end

        XFER_RD: begin
          // Requests keep issuing without waiting for data to return.
          if (mem_gnt_i && (iss_q != BEATS_C)) begin
            iss_q <= iss_q + CW'(1);
          end
          if (mem_rvalid_i) begin
            for (int k = 0; k < N_BEATS; k++) begin
              if (rsp_q == CW'(k)) begin
                line_q[k*64 +: 64] <= mem_rdata_i;
              end
            end
            rsp_q <= rsp_q + CW'(1);
            if (rsp_q == LAST_C) begin
              state_q <= XFER_DONE;
            end
          end
        end

        XFER_DONE: begin
          state_q <= XFER_IDLE;
        end

        default: begin
          state_q <= XFER_IDLE;
        end
      endcase
    end
  end

  // Select the write beat addressed by the issue counter. Only registered
  // state feeds this, so a stalled grant keeps the beat steady.
  always_comb begin
    wbeat_d = '0;
    for (int k = 0; k < N_BEATS; k++) begin
      if (iss_q == CW'(k)) begin
        wbeat_d = wline_q[k*64 +: 64];
      end
    end
  end

  // Memory-side outputs are decoded purely from registers; all of them
  // are forced to zero whenever no request is being presented.
  always_comb begin
    req_d = (state_q == XFER_WR) ||
            ((state_q == XFER_RD) && (iss_q < BEATS_C));
  end

  assign mem_req_o    = req_d;
  assign mem_we_o     = req_d && (state_q == XFER_WR);
  assign mem_be_o     = req_d ? 8'hFF : 8'h00;
  assign mem_addr_o   = req_d ? (base_q + beat_offset(64'(iss_q))) : 64'd0;
  assign mem_wdata_o  = (req_d && (state_q == XFER_WR)) ? wbeat_d : 64'd0;

  assign cmd_ready_o  = (state_q == XFER_IDLE);
  assign done_o       = (state_q == XFER_DONE);
  assign line_rdata_o = line_q;

endmodule

// File: tb/tb_rv64g_l1_line_xfer.sv
// ---------------------------------------------------------------------------
// tb_rv64g_l1_line_xfer
// Directed bench for the line-transfer engine. A small memory model answers
// the beat port with a configurable grant throttle and read latency. Every
// expected beat (address/direction/data) is queued when a command is issued
// and checked as the engine presents it; refill lines are compared against
// bench-built constants.
// ---------------------------------------------------------------------------
module tb_rv64g_l1_line_xfer;

  localparam int LB = 64;
  localparam int LW = LB * 8;
  localparam int NB = LB / 8;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    int          due;
    logic [63:0] data;
  } pend_t;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [63:0]   cmd_addr;
  logic [LW-1:0] cmd_wdata;
  logic          done;
  logic [LW-1:0] line_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [7:0]    mem_be;
  logic [63:0]   mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  bit [63:0] memArr [bit [63:0]];
  beat_t     expQ[$];
  pend_t     pend[$];

  int cyc        = 0;
  int rdDelay    = 2;
  int gntPeriod  = 1;
  bit strayRv    = 0;
  int rvCount    = 0;
  int doneTotal  = 0;

  logic [LW-1:0] preLine;
  logic [LW-1:0] wbLine;
  logic [LW-1:0] thrLine;
  logic [LW-1:0] strayLine;
  logic [LW-1:0] curLine;

  rv64g_l1_line_xfer #(.LINE_BYTES(LB)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_we_i     (cmd_we),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .done_o       (done),
    .line_rdata_o (line_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs,
                             input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model and beat scoreboard, evaluated mid-cycle so the DUT's
  // registered outputs are stable and model responses are set up before
  // the next rising edge.
  always @(negedge clk) begin
    beat_t b;
    pend_t p;
    cyc++;
    if (strayRv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = {$urandom, $urandom};
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      p          = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = p.data;
      rvCount++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
    mem_gnt = mem_req && (gntPeriod <= 1 || (cyc % gntPeriod) == 0);
    if (done) doneTotal++;
    if (mem_req) begin
      checkOutput("beatExpected", (expQ.size() > 0) ? 1 : 0, 1);
      if (expQ.size() > 0) begin
        checkOutput("beatAddr", mem_addr, expQ[0].addr);
        checkOutput("beatWe", mem_we, expQ[0].we);
        checkOutput("beatData", mem_wdata, expQ[0].wdata);
        checkOutput("beatBe", mem_be, 8'hFF);
        if (mem_gnt) begin
          b = expQ.pop_front();
          if (b.we) begin
            memArr[b.addr >> 3] = mem_wdata;
          end else begin
            p.due  = cyc + rdDelay;
            p.data = memArr[b.addr >> 3];
            pend.push_back(p);
          end
        end
      end
    end else begin
      checkOutput("idleBus", {mem_we, mem_be, mem_addr, mem_wdata}, '0);
    end
  end

  // Issue one line command, queue its expected beats, and wait (bounded)
  // for completion; reports the done cycle (accept edge = 0) and pulse count.
  task automatic applyStimulus(input bit we, input logic [63:0] addr,
                               input logic [63:0] base, input logic [LW-1:0] wline,
                               input int delay, input int gntPer, input bit stray,
                               output int doneCyc, output int doneCnt);
    beat_t b;
    rdDelay   = delay;
    gntPeriod = gntPer;
    for (int k = 0; k < NB; k++) begin
      b.addr  = base + 64'(8 * k);
      b.we    = we;
      b.wdata = we ? wline[k*64 +: 64] : 64'd0;
      expQ.push_back(b);
    end
    @(negedge clk);
    #1;
    checkOutput("cmdReady", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wline;
    strayRv   = stray;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_wdata = '1;
    doneCyc   = -1;
    doneCnt   = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (doneCyc >= 0 && c >= doneCyc + 3) break;
    end
    strayRv   = 1'b0;
    gntPeriod = 1;
    checkOutput("beatsLeft", expQ.size(), 0);
  endtask

  initial begin
    int dc;
    int dn;
    int startRv;
    int doneBefore;

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    for (int k = 0; k < NB; k++) begin
      memArr[64'h200 + 64'(k)] = 64'hA5A5_0000_0000_0000 + 64'(k);
      preLine[k*64 +: 64]   = 64'hA5A5_0000_0000_0000 + 64'(k);
      wbLine[k*64 +: 64]    = 64'h1111_1111_1111_1111 * 64'(k);
      thrLine[k*64 +: 64]   = 64'hDEAD_0000_0000_0000 + 64'(k * 257);
      strayLine[k*64 +: 64] = 64'h5555_0000_0000_0000 + 64'(k);
    end

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReady", cmd_ready, 1'b1);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstReq", mem_req, 1'b0);
    checkOutput("rstWe", mem_we, 1'b0);
    checkOutput("rstBe", mem_be, 8'h00);
    checkOutput("rstAddr", mem_addr, 64'd0);
    checkOutput("rstWdata", mem_wdata, 64'd0);
    checkOutput("rstLine", line_rdata, '0);
    #1;
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Refill of preloaded memory, rvalid two cycles after grant.
    applyStimulus(1'b0, 64'h1000, 64'h1000, '0, 2, 1, 1'b0, dc, dn);
    checkOutput("rd1DoneCyc", dc, 11);
    checkOutput("rd1DoneCnt", dn, 1);
    checkOutput("rd1Line", line_rdata, preLine);
    curLine = preLine;

    // Writeback then refill through an unaligned address.
    applyStimulus(1'b1, 64'h2040, 64'h2040, wbLine, 2, 1, 1'b0, dc, dn);
    checkOutput("wr1DoneCyc", dc, 9);
    checkOutput("wr1DoneCnt", dn, 1);
    checkOutput("wr1LineKept", line_rdata, curLine);
    applyStimulus(1'b0, 64'h207F, 64'h2040, '0, 2, 1, 1'b0, dc, dn);
    checkOutput("rd2DoneCyc", dc, 11);
    checkOutput("rd2Line", line_rdata, wbLine);
    curLine = wbLine;

    // Writeback with grant every third cycle, verified by reading it back.
    applyStimulus(1'b1, 64'h4000, 64'h4000, thrLine, 2, 3, 1'b0, dc, dn);
    checkOutput("thrDoneCnt", dn, 1);
    checkOutput("thrLineKept", line_rdata, curLine);
    applyStimulus(1'b0, 64'h4000, 64'h4000, '0, 2, 1, 1'b0, dc, dn);
    checkOutput("thrReadback", line_rdata, thrLine);
    curLine = thrLine;

    // Longer read latency so returns overlap later grants.
    applyStimulus(1'b0, 64'h1000, 64'h1000, '0, 5, 1, 1'b0, dc, dn);
    checkOutput("rd5DoneCyc", dc, 14);
    checkOutput("rd5DoneCnt", dn, 1);
    checkOutput("rd5Line", line_rdata, preLine);
    curLine = preLine;

    // Reset asserted after three read beats have returned.
    begin
      beat_t b;
      rdDelay   = 2;
      gntPeriod = 1;
      for (int k = 0; k < NB; k++) begin
        b.addr  = 64'h1000 + 64'(8 * k);
        b.we    = 1'b0;
        b.wdata = 64'd0;
        expQ.push_back(b);
      end
    end
    startRv = rvCount;
    @(negedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 64'h1000;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && (rvCount - startRv) < 3; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortPoint", rvCount - startRv, 3);
    checkOutput("abortReady", cmd_ready, 1'b1);
    checkOutput("abortReq", mem_req, 1'b0);
    checkOutput("abortDone", done, 1'b0);
    checkOutput("abortLine", line_rdata, '0);
    doneBefore = doneTotal;
    pend.delete();
    expQ.delete();
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("abortNoDone", doneTotal, doneBefore);
    applyStimulus(1'b0, 64'h1000, 64'h1000, '0, 2, 1, 1'b0, dc, dn);
    checkOutput("postRstDoneCyc", dc, 11);
    checkOutput("postRstLine", line_rdata, preLine);
    curLine = preLine;

    // Stray rvalid while idle and while writing back.
    doneBefore = doneTotal;
    strayRv = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    strayRv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("strayIdleLine", line_rdata, curLine);
    checkOutput("strayIdleDone", doneTotal, doneBefore);
    applyStimulus(1'b1, 64'h3000, 64'h3000, strayLine, 2, 1, 1'b1, dc, dn);
    checkOutput("strayWrDoneCyc", dc, 9);
    checkOutput("strayWrDoneCnt", dn, 1);
    checkOutput("strayWrLine", line_rdata, curLine);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
